// File: rtl/posit_pkg.sv
// Shared constants, bundle layout and FSM encoding for the posit decode scheduler.
// Constants here describe the default 8-bit / es=2 configuration.
package posit_pkg;

  localparam int P_WIDTH = 8;
  localparam int P_EXP   = 2;
  localparam int REGI    = $clog2(P_WIDTH) + 1;
  localparam int MTS     = P_WIDTH - 3 - P_EXP;

  function automatic int res_w(input int width, input int exp);
    return 2*(width-2) + 1 + 2 + 2*($clog2(width)+1) + 2*exp + 2*(width-3-exp) + 4;
  endfunction

  localparam int RES_W = res_w(P_WIDTH, P_EXP);

  // Bundle layout, LSB upward; each vld field is a 2-bit class code (zero/normal/NaR).
  localparam int OFF_VLD_D    = 0;
  localparam int OFF_VLD_W    = OFF_VLD_D + 2;
  localparam int OFF_MTS_L    = OFF_VLD_W + 2;
  localparam int OFF_MTS_S    = OFF_MTS_L + MTS;
  localparam int OFF_EXP_L    = OFF_MTS_S + MTS;
  localparam int OFF_EXP_S    = OFF_EXP_L + P_EXP;
  localparam int OFF_REGI_L   = OFF_EXP_S + P_EXP;
  localparam int OFF_REGI_S   = OFF_REGI_L + REGI;
  localparam int OFF_SIGN_L   = OFF_REGI_S + REGI;
  localparam int OFF_SIGN_S   = OFF_SIGN_L + 1;
  localparam int OFF_REGI_EXT = OFF_SIGN_S + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/posit_dec_scheduler_res_fifo.sv
// In-order result FIFO with occupancy count; pointers wrap modulo DEPTH so any depth works.
module res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wrap_inc(wr_ptr);
      if (rd_en) rd_ptr <= wrap_inc(rd_ptr);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

  // The scheduler's credit check must make a write into a full FIFO impossible.
  overflow_chk: assert property (@(posedge clk_i) disable iff (!rstn)
    !(wr_en && !rd_en && count == CW'(DEPTH)));

endmodule

// File: rtl/posit_dec_scheduler.sv
// Round-robin scheduler sharing one registered posit pair decoder among NREQ requesters,
// with credit-protected buffering of decoded bundles.
module posit_dec_scheduler
  import posit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int RES_W = res_w(WIDTH, EXP),
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_vld_i,
  output logic [NREQ-1:0]       req_rdy_o,
  input  logic [NREQ*WIDTH-1:0] req_win_i,
  input  logic [NREQ*WIDTH-1:0] req_din_i,
  output logic                  dec_vld_o,
  output logic [WIDTH-1:0]      dec_win_o,
  output logic [WIDTH-1:0]      dec_din_o,
  input  logic [RES_W-1:0]      dec_res_i,
  output logic                  rsp_vld_o,
  input  logic                  rsp_rdy_i,
  output logic [RES_W-1:0]      rsp_res_o,
  output logic [IDW-1:0]        rsp_id_o,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  // Handshakes: a requester transfers on req_vld_i[k] & req_rdy_o[k]; the consumer on
  // rsp_vld_o & rsp_rdy_i. Data must stay stable while valid is high and ready is low.

  localparam int CW = $clog2(DEPTH+1);

  state_t                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, gnt_id, id1_q, id2_q;
  logic [IDW:0]           idx;
  logic                   gnt_found, grant, v1_q, v2_q, pop, credit_ok, drained;
  logic [WIDTH-1:0]       sel_win, sel_din;
  logic [CW-1:0]          count;
  logic [IDW+RES_W-1:0]   fifo_rd;

  assign pop       = rsp_vld_o & rsp_rdy_i;
  assign credit_ok = (int'(count) + int'(v1_q) + int'(v2_q) - int'(pop)) < DEPTH;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!gnt_found && req_vld_i[idx[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_win = '0;
    sel_din = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_win = req_win_i[k*WIDTH +: WIDTH];
        sel_din = req_din_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // A flush request wins over a grant in the same cycle.
  assign grant = rstn & gnt_found & credit_ok & ~flush_i & (state_q != FLUSH);

  always_comb begin
    req_rdy_o = '0;
    if (grant) req_rdy_o[gnt_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    drained = ~v1_q & ~v2_q & ((int'(count) - int'(pop)) == 0);
    unique case (state_q)
      IDLE: begin
        if (flush_i)         state_d = FLUSH;
        else if (|req_vld_i) state_d = RUN;
      end
      RUN: begin
        if (flush_i) state_d = FLUSH;
        else if (!(|req_vld_i) && !v1_q && !v2_q && count == '0) state_d = IDLE;
      end
      FLUSH: begin
        if (drained) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      id1_q        <= '0;
      id2_q        <= '0;
      dec_win_o    <= '0;
      dec_din_o    <= '0;
      flush_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      v1_q         <= grant;
      id1_q        <= gnt_id;
      v2_q         <= v1_q;
      id2_q        <= id1_q;
      flush_done_o <= (state_q == FLUSH) & drained;
      if (grant) begin
        rr_ptr_q  <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
        dec_win_o <= sel_win;
        dec_din_o <= sel_din;
      end
    end
  end

  // v2 marks the cycle in which dec_res_i carries the pair issued two cycles earlier.
  res_fifo #(
    .W     (IDW+RES_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rstn    (rstn),
    .wr_en   (v2_q),
    .wr_data ({id2_q, dec_res_i}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (count)
  );

  assign dec_vld_o = v1_q;
  assign rsp_vld_o = (count != '0);
  assign rsp_res_o = rsp_vld_o ? fifo_rd[RES_W-1:0] : '0;
  assign rsp_id_o  = rsp_vld_o ? fifo_rd[RES_W +: IDW] : '0;
  assign busy_o    = v1_q | v2_q | (count != '0);
  assign state_o   = state_q;

endmodule
